// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the front-panel time-setting controller:
// FSM state encoding, load-protocol codes, edit-field codes, field limits
// and the wrap-around step used for editing.
package time_set_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EDIT_HOUR,
      ST_EDIT_MIN,
      ST_EDIT_REMIND,
      ST_COMMIT_TIME,
      ST_COMMIT_REMIND
   } state_t;

   localparam logic [1:0] SET_RUN    = 2'b00;
   localparam logic [1:0] SET_TIME   = 2'b01;
   localparam logic [1:0] SET_REMIND = 2'b10;

   localparam logic [1:0] FIELD_NONE   = 2'b00;
   localparam logic [1:0] FIELD_HOUR   = 2'b01;
   localparam logic [1:0] FIELD_MIN    = 2'b10;
   localparam logic [1:0] FIELD_REMIND = 2'b11;

   localparam logic [5:0] HOUR_MAX       = 6'd23;
   localparam logic [5:0] MIN_MAX        = 6'd59;
   localparam logic [5:0] REMIND_MIN     = 6'd1;
   localparam logic [5:0] REMIND_DEFAULT = 6'd10;

   // One up/down step inside [lo, hi] with wrap-around. A value that was
   // preloaded outside the range snaps to the field minimum.
   function automatic logic [5:0] step_wrap(input logic [5:0] val,
                                            input logic [5:0] lo,
                                            input logic [5:0] hi,
                                            input logic       up);
      if (val < lo || val > hi) return lo;
      if (up) return (val == hi) ? lo : val + 6'd1;
      return (val == lo) ? hi : val - 6'd1;
   endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Raw push-button conditioner: 2-flop synchroniser, stable-level
// down-counter and a one-clk pulse on each accepted rising edge.
// Ports: clk, reset (async, active-high), raw (button pin), pulse (1 clk).
module btn_debounce #(
   parameter int CYCLES = 2_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic pulse
);

   localparam int CW = $clog2(CYCLES + 1);

   logic          sync0;
   logic          sync1;
   logic          stable;
   logic [CW-1:0] cnt;

   // The counter reloads whenever the synchronised level agrees with the
   // accepted level, so a new level must persist CYCLES clocks to win.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync0  <= 1'b0;
         sync1  <= 1'b0;
         stable <= 1'b0;
         pulse  <= 1'b0;
         cnt    <= '0;
      end else begin
         sync0 <= raw;
         sync1 <= sync0;
         pulse <= 1'b0;
         if (sync1 == stable) begin
            cnt <= CW'(CYCLES - 1);
         end else if (cnt == '0) begin
            stable <= sync1;
            pulse  <= sync1;
            cnt    <= CW'(CYCLES - 1);
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel time-setting controller. Edits a shadow copy of the clock
// hour/minute and the remind threshold, then holds a load code on
// set_all_times long enough for the 100 Hz timekeeper to capture it.
// Ports: clk, reset (async, active-high), power_on, btn_mode/up/down/
// confirm (raw buttons), cur_hour/cur_minute/cur_remind_hour (preload),
// set_all_times, btn_time_set, btn_min_set (load interface),
// editing, edit_field, blink (display hints).
//
// state            | meaning
// ST_IDLE          | running, waiting for mode to start an edit
// ST_EDIT_HOUR     | up/down change shadow hour
// ST_EDIT_MIN      | up/down change shadow minute
// ST_EDIT_REMIND   | up/down change shadow remind threshold
// ST_COMMIT_TIME   | driving load code 01 with hour/minute
// ST_COMMIT_REMIND | driving load code 10 with remind threshold
module time_set_ctrl
   import time_set_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 2_000_000,
   parameter int COMMIT_CYCLES   = 3_000_000,
   parameter int TIMEOUT_CYCLES  = 1_000_000_000,
   parameter int BLINK_CYCLES    = 25_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       power_on,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_confirm,
   input  logic [5:0] cur_hour,
   input  logic [5:0] cur_minute,
   input  logic [5:0] cur_remind_hour,
   output logic [1:0] set_all_times,
   output logic [5:0] btn_time_set,
   output logic [5:0] btn_min_set,
   output logic       editing,
   output logic [1:0] edit_field,
   output logic       blink
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CW = $clog2(COMMIT_CYCLES + 1);
   localparam int BW = $clog2(BLINK_CYCLES + 1);

   logic mode_p, up_p, down_p, confirm_p;

   btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk(clk), .reset(reset), .raw(btn_mode), .pulse(mode_p));
   btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk(clk), .reset(reset), .raw(btn_up), .pulse(up_p));
   btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_down (
      .clk(clk), .reset(reset), .raw(btn_down), .pulse(down_p));
   btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_confirm (
      .clk(clk), .reset(reset), .raw(btn_confirm), .pulse(confirm_p));

   state_t        state, state_nxt;
   logic [5:0]    hour, minute, remind;
   logic [5:0]    hour_nxt, minute_nxt, remind_nxt;
   logic [TW-1:0] idle_cnt;
   logic [CW-1:0] commit_cnt;
   logic [BW-1:0] blink_cnt;
   logic          step_up, step_dn, any_pulse, state_change, edit_nxt;

   // Opposing pulses in the same cycle cancel.
   assign step_up      = up_p & ~down_p;
   assign step_dn      = down_p & ~up_p;
   assign any_pulse    = mode_p | up_p | down_p | confirm_p;
   assign state_change = (state_nxt != state);
   assign edit_nxt     = (state_nxt == ST_EDIT_HOUR) || (state_nxt == ST_EDIT_MIN) ||
                         (state_nxt == ST_EDIT_REMIND);

   always_comb begin
      state_nxt  = state;
      hour_nxt   = hour;
      minute_nxt = minute;
      remind_nxt = remind;
      if (!power_on) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mode_p) begin
                  state_nxt  = ST_EDIT_HOUR;
                  hour_nxt   = cur_hour;
                  minute_nxt = cur_minute;
                  remind_nxt = cur_remind_hour;
               end
            end
            ST_EDIT_HOUR, ST_EDIT_MIN, ST_EDIT_REMIND: begin
               if (confirm_p) begin
                  state_nxt = (state == ST_EDIT_REMIND) ? ST_COMMIT_REMIND : ST_COMMIT_TIME;
               end else if (mode_p) begin
                  case (state)
                     ST_EDIT_HOUR: state_nxt = ST_EDIT_MIN;
                     ST_EDIT_MIN:  state_nxt = ST_EDIT_REMIND;
                     default:      state_nxt = ST_EDIT_HOUR;
                  endcase
               end else if (step_up || step_dn) begin
                  case (state)
                     ST_EDIT_HOUR: hour_nxt   = step_wrap(hour, 6'd0, HOUR_MAX, step_up);
                     ST_EDIT_MIN:  minute_nxt = step_wrap(minute, 6'd0, MIN_MAX, step_up);
                     default:      remind_nxt = step_wrap(remind, REMIND_MIN, HOUR_MAX, step_up);
                  endcase
               end else if (idle_cnt == '0 && !any_pulse) begin
                  state_nxt = ST_IDLE;
               end
            end
            ST_COMMIT_TIME, ST_COMMIT_REMIND: begin
               if (commit_cnt == '0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         hour          <= '0;
         minute        <= '0;
         remind        <= REMIND_DEFAULT;
         idle_cnt      <= '0;
         commit_cnt    <= '0;
         blink_cnt     <= '0;
         set_all_times <= SET_RUN;
         btn_time_set  <= '0;
         btn_min_set   <= '0;
         editing       <= 1'b0;
         edit_field    <= FIELD_NONE;
         blink         <= 1'b0;
      end else begin
         state  <= state_nxt;
         hour   <= hour_nxt;
         minute <= minute_nxt;
         remind <= remind_nxt;

         if (state_change || any_pulse) idle_cnt <= TW'(TIMEOUT_CYCLES - 1);
         else if (idle_cnt != '0)       idle_cnt <= idle_cnt - 1'b1;

         if (state_change)            commit_cnt <= CW'(COMMIT_CYCLES - 1);
         else if (commit_cnt != '0)   commit_cnt <= commit_cnt - 1'b1;

         // A new field starts lit with a fresh half-period.
         if (!edit_nxt) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
         end else if (state_change) begin
            blink     <= 1'b1;
            blink_cnt <= BW'(BLINK_CYCLES - 1);
         end else if (blink_cnt == '0) begin
            blink     <= ~blink;
            blink_cnt <= BW'(BLINK_CYCLES - 1);
         end else begin
            blink_cnt <= blink_cnt - 1'b1;
         end

         set_all_times <= SET_RUN;
         btn_time_set  <= hour_nxt;
         btn_min_set   <= minute_nxt;
         editing       <= edit_nxt;
         edit_field    <= FIELD_NONE;
         case (state_nxt)
            ST_EDIT_HOUR: edit_field <= FIELD_HOUR;
            ST_EDIT_MIN:  edit_field <= FIELD_MIN;
            ST_EDIT_REMIND: begin
               edit_field   <= FIELD_REMIND;
               btn_time_set <= remind_nxt;
            end
            ST_COMMIT_TIME: set_all_times <= SET_TIME;
            ST_COMMIT_REMIND: begin
               set_all_times <= SET_REMIND;
               btn_time_set  <= remind_nxt;
               btn_min_set   <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

   localparam int HOLD = 10;
   localparam int B_MODE = 0, B_UP = 1, B_DOWN = 2, B_CONFIRM = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       power_on = 1'b1;
   logic [3:0] btn = 4'b0;
   logic [5:0] cur_hour = 6'd0, cur_minute = 6'd0, cur_remind_hour = 6'd0;
   logic [1:0] set_all_times;
   logic [5:0] btn_time_set, btn_min_set;
   logic       editing, blink;
   logic [1:0] edit_field;

   int checks = 0;
   int errors = 0;

   // reference model: field 0 none, 1 hour, 2 minute, 3 remind
   int m_field = 0, m_h = 0, m_m = 0, m_r = 10;

   time_set_ctrl #(
      .DEBOUNCE_CYCLES(4), .COMMIT_CYCLES(8), .TIMEOUT_CYCLES(64), .BLINK_CYCLES(4)
   ) dut (
      .clk(clk), .reset(reset), .power_on(power_on),
      .btn_mode(btn[0]), .btn_up(btn[1]), .btn_down(btn[2]), .btn_confirm(btn[3]),
      .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_remind_hour(cur_remind_hour),
      .set_all_times(set_all_times), .btn_time_set(btn_time_set), .btn_min_set(btn_min_set),
      .editing(editing), .edit_field(edit_field), .blink(blink)
   );

   always #5 clk = ~clk;

   // load-protocol monitor: records each run of non-zero set_all_times
   int mon_runs = 0, mon_len = 0, run_len = 0, mon_cyc01 = 0, mon_bad = 0;
   logic [1:0] mon_code = 2'b00;
   logic [5:0] mon_t = 6'd0, mon_m = 6'd0;

   always @(negedge clk) begin
      if (set_all_times != 2'b00) begin
         if (run_len == 0) begin
            mon_code <= set_all_times;
            mon_t    <= btn_time_set;
            mon_m    <= btn_min_set;
         end else if (set_all_times !== mon_code || btn_time_set !== mon_t ||
                      btn_min_set !== mon_m) begin
            mon_bad <= mon_bad + 1;
         end
         run_len <= run_len + 1;
         if (set_all_times == 2'b01) mon_cyc01 <= mon_cyc01 + 1;
      end else if (run_len != 0) begin
         mon_len  <= run_len;
         mon_runs <= mon_runs + 1;
         run_len  <= 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, want);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input int b);
      btn[b] = 1'b1;
      tick(HOLD);
      btn[b] = 1'b0;
      tick(HOLD);
   endtask

   function automatic int step_field(input int field, input int v, input bit up);
      if (field == 1) begin
         if (v > 23) return 0;
         return up ? (v + 1) % 24 : (v + 23) % 24;
      end else if (field == 2) begin
         if (v > 59) return 0;
         return up ? (v + 1) % 60 : (v + 59) % 60;
      end
      if (v < 1 || v > 23) return 1;
      return up ? (v % 23) + 1 : ((v + 21) % 23) + 1;
   endfunction

   task automatic model_apply(input int b, output bit commit, output int ecode,
                              output int et, output int em);
      commit = 1'b0; ecode = 0; et = 0; em = 0;
      if (m_field == 0) begin
         if (b == B_MODE) begin
            m_field = 1; m_h = cur_hour; m_m = cur_minute; m_r = cur_remind_hour;
         end
      end else begin
         case (b)
            B_MODE: m_field = m_field % 3 + 1;
            B_CONFIRM: begin
               commit = 1'b1;
               ecode  = (m_field == 3) ? 2 : 1;
               et     = (m_field == 3) ? m_r : m_h;
               em     = (m_field == 3) ? 0 : m_m;
               m_field = 0;
            end
            default: begin
               if (m_field == 1)      m_h = step_field(1, m_h, b == B_UP);
               else if (m_field == 2) m_m = step_field(2, m_m, b == B_UP);
               else                   m_r = step_field(3, m_r, b == B_UP);
            end
         endcase
      end
   endtask

   task automatic chk_view();
      chk("editing", editing, m_field != 0);
      chk("edit_field", edit_field, m_field);
      chk("time_view", btn_time_set, (m_field == 3) ? m_r : m_h);
      chk("min_view", btn_min_set, m_m);
   endtask

   task automatic do_press(input int b);
      int runs0, ecode, et, em;
      bit commit;
      runs0 = mon_runs;
      press(b);
      model_apply(b, commit, ecode, et, em);
      chk("commit_runs", mon_runs - runs0, commit);
      if (commit) begin
         chk("commit_code", mon_code, ecode);
         chk("commit_len", mon_len, 8);
         chk("commit_time", mon_t, et);
         chk("commit_min", mon_m, em);
      end
      chk("set_all_times_idle", set_all_times, 0);
      chk_view();
   endtask

   initial begin
      int tr, c01, r;
      logic prev;

      // reset state
      tick(3);
      chk("rst_set", set_all_times, 0);
      chk("rst_time", btn_time_set, 0);
      chk("rst_min", btn_min_set, 0);
      chk("rst_editing", editing, 0);
      chk("rst_field", edit_field, 0);
      chk("rst_blink", blink, 0);
      reset = 1'b0;
      tick(3);

      // basic set: 12:30 -> 14:30
      cur_hour = 6'd12; cur_minute = 6'd30; cur_remind_hour = 6'd5;
      do_press(B_MODE);
      do_press(B_UP);
      do_press(B_UP);
      chk("basic_hour", btn_time_set, 14);
      do_press(B_CONFIRM);
      chk("basic_len", mon_len, 8);
      chk("basic_t", mon_t, 14);

      // wrap-around
      cur_hour = 6'd0; cur_minute = 6'd59;
      do_press(B_MODE);
      do_press(B_MODE);
      do_press(B_UP);
      chk("wrap_min_up", btn_min_set, 0);
      do_press(B_DOWN);
      chk("wrap_min_down", btn_min_set, 59);
      do_press(B_MODE);
      do_press(B_MODE);
      do_press(B_DOWN);
      chk("wrap_hour_down", btn_time_set, 23);
      do_press(B_CONFIRM);

      // remind wrap and commit
      cur_remind_hour = 6'd23;
      do_press(B_MODE);
      do_press(B_MODE);
      do_press(B_MODE);
      do_press(B_UP);
      chk("remind_wrap", btn_time_set, 1);
      do_press(B_CONFIRM);
      chk("remind_code", mon_code, 2);
      chk("remind_t", mon_t, 1);
      chk("remind_m", mon_m, 0);

      // bounce on up -> exactly one increment
      cur_hour = 6'd5;
      do_press(B_MODE);
      for (int i = 0; i < 10; i++) begin
         btn[B_UP] = ~btn[B_UP];
         tick(2);
      end
      btn[B_UP] = 1'b1;
      tick(HOLD);
      btn[B_UP] = 1'b0;
      tick(HOLD);
      m_h = step_field(1, m_h, 1'b1);
      chk("bounce_hour", btn_time_set, 6);
      chk_view();

      // simultaneous up+down -> unchanged
      btn[B_UP] = 1'b1; btn[B_DOWN] = 1'b1;
      tick(HOLD);
      btn[B_UP] = 1'b0; btn[B_DOWN] = 1'b0;
      tick(HOLD);
      chk("simul_hour", btn_time_set, 6);
      chk_view();

      // blink toggles every 4 clk while editing
      tr = 0;
      @(negedge clk);
      prev = blink;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (blink !== prev) tr++;
         prev = blink;
      end
      chk("blink_toggles", tr, 4);

      // power drop mid-commit
      btn[B_CONFIRM] = 1'b1;
      for (int i = 0; i < 40 && set_all_times !== 2'b01; i++) @(negedge clk);
      chk("abort_commit_seen", set_all_times, 1);
      @(posedge clk);
      #1;
      power_on = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_set", set_all_times, 0);
      chk("abort_editing", editing, 0);
      btn[B_CONFIRM] = 1'b0;
      tick(12);
      power_on = 1'b1;
      m_field = 0;
      tick(2);
      chk_view();

      // timeout in EDIT_MIN
      cur_hour = 6'd7; cur_minute = 6'd8;
      do_press(B_MODE);
      do_press(B_MODE);
      c01 = mon_cyc01;
      tick(30);
      chk("timeout_still_edit", editing, 1);
      tick(50);
      chk("timeout_editing", editing, 0);
      chk("timeout_field", edit_field, 0);
      chk("timeout_no_load", mon_cyc01 - c01, 0);
      m_field = 0;

      // randomized sequence against the model
      for (int n = 0; n < 40; n++) begin
         if (m_field == 0) begin
            cur_hour        = 6'($urandom_range(0, 63));
            cur_minute      = 6'($urandom_range(0, 63));
            cur_remind_hour = 6'($urandom_range(0, 63));
            do_press(($urandom_range(0, 4) == 0) ? B_UP : B_MODE);
         end else begin
            r = $urandom_range(0, 9);
            if (r == 0)      do_press(B_CONFIRM);
            else if (r < 3)  do_press(B_MODE);
            else if (r < 7)  do_press(B_UP);
            else             do_press(B_DOWN);
         end
      end
      if (m_field != 0) do_press(B_CONFIRM);

      // asynchronous reset mid-commit
      cur_hour = 6'd9; cur_minute = 6'd41;
      do_press(B_MODE);
      btn[B_CONFIRM] = 1'b1;
      for (int i = 0; i < 40 && set_all_times !== 2'b01; i++) @(negedge clk);
      chk("rstmid_seen", set_all_times, 1);
      #3;
      reset = 1'b1;
      #1;
      chk("rstmid_set", set_all_times, 0);
      chk("rstmid_time", btn_time_set, 0);
      chk("rstmid_min", btn_min_set, 0);
      btn[B_CONFIRM] = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(12);
      m_field = 0; m_h = 0; m_m = 0; m_r = 10;
      chk_view();

      chk("commit_stable", mon_bad, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Front-panel time-setting controller; the writer side of the timekeeper's set interface.
- Turns raw mode/up/down/confirm buttons into the `set_all_times`, `btn_time_set` and `btn_min_set` load protocol.
  - Code 01 loads clock hour/minute.
  - Code 10 loads the work-time remind threshold.
- Edits a shadow copy, then holds the load code long enough for the timekeeper's 100 Hz sampling domain to capture it.

Parameters:
- DEBOUNCE_CYCLES, 2_000_000, stable-level cycles before a button edge is accepted (20 ms at 100 MHz).
- COMMIT_CYCLES, 3_000_000, cycles the load code is held; must cover at least two 100 Hz periods.
- TIMEOUT_CYCLES, 1_000_000_000, idle cycles in an edit state before abandoning the edit (10 s).
- BLINK_CYCLES, 25_000_000, half-period of the edit-field blink.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- power_on  in  1  appliance powered; low aborts any edit
- btn_mode  in  1  raw button: enter edit / cycle field
- btn_up  in  1  raw button: increment field
- btn_down  in  1  raw button: decrement field
- btn_confirm  in  1  raw button: commit
- cur_hour  in  6  live clock hour, preload source
- cur_minute  in  6  live clock minute, preload source
- cur_remind_hour  in  6  live remind threshold, preload source
- set_all_times  out  2  00 run, 01 load time, 10 load remind; 11 never driven
- btn_time_set  out  6  hour or remind value being written
- btn_min_set  out  6  minute value being written
- editing  out  1  high in any EDIT state
- edit_field  out  2  00 none, 01 hour, 10 minute, 11 remind
- blink  out  1  display blink for the selected field

Behaviour:
- Reset values (asynchronous, active-high):
  - state IDLE; all outputs 0; shadow hour/minute 0; shadow remind 10; all counters 0.
- Inputs:
  - Each raw button passes through a 2-flop synchroniser and a debouncer.
  - The debouncer emits a one-clk pulse on each accepted rising edge. A button held down produces exactly one pulse; there is no auto-repeat.
  - Press latency from raw edge to pulse is DEBOUNCE_CYCLES+3 clk.
- States: IDLE, EDIT_HOUR, EDIT_MIN, EDIT_REMIND, COMMIT_TIME, COMMIT_REMIND.
- Priority within a cycle: power_on low > confirm > mode > up/down.
  - up and down pulsing in the same cycle is ignored.
- IDLE:
  - A mode pulse with power_on=1 moves to EDIT_HOUR.
  - On entry, shadow hour/minute are loaded from cur_hour/cur_minute, and shadow remind from cur_remind_hour.
  - Other pulses are ignored.
- EDIT_HOUR -> mode -> EDIT_MIN -> mode -> EDIT_REMIND -> mode -> EDIT_HOUR.
- Arithmetic in edit states:
  - up/down modify only the selected field, with wrap-around.
  - hour: 0..23 (23+1=0, 0-1=23).
  - minute: 0..59.
  - remind: 1..23 (23+1=1, 1-1=23).
  - If a preloaded value is out of range, the first up or down forces it to the field minimum.
- confirm:
  - In EDIT_HOUR or EDIT_MIN -> COMMIT_TIME.
  - In EDIT_REMIND -> COMMIT_REMIND.
- COMMIT_TIME:
  - set_all_times=01, btn_time_set=shadow hour, btn_min_set=shadow minute.
  - Held for exactly COMMIT_CYCLES clk, then IDLE.
  - All button pulses are ignored.
- COMMIT_REMIND:
  - set_all_times=10, btn_time_set=shadow remind, btn_min_set=0.
  - Held for exactly COMMIT_CYCLES clk, then IDLE.
- Outputs outside COMMIT states:
  - set_all_times=00.
  - btn_time_set/btn_min_set show the shadow hour/minute (in EDIT_REMIND, btn_time_set shows shadow remind) for display.
- Abort:
  - power_on=0 in any EDIT or COMMIT state returns to IDLE next clk, with set_all_times=00 from that clk.
  - A partially held commit is acceptable because the consumer's load is idempotent.
- Timeout:
  - The idle counter is cleared by any accepted pulse and on state entry.
  - Reaching TIMEOUT_CYCLES in an EDIT state returns to IDLE with no commit.
- blink:
  - Toggles every BLINK_CYCLES while editing; forced 0 otherwise.
  - The blink counter restarts on every field change so a new field is shown immediately.
- editing and edit_field are registered and follow the state with no extra latency.
- Reset mid-commit: outputs drop to 0 immediately, without waiting for clk.

Decomposition:
- Shared package holds:
  - the state enum;
  - SET_RUN=2'b00, SET_TIME=2'b01, SET_REMIND=2'b10;
  - field codes;
  - HOUR_MAX=23, MIN_MAX=59, REMIND_MIN=1, REMIND_DEFAULT=10.
- One sub-module, btn_debounce (synchroniser + stable counter + rising-edge pulse), instantiated four times.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, COMMIT_CYCLES=8, TIMEOUT_CYCLES=64, BLINK_CYCLES=4):
- Reset, then cur_hour=12, cur_minute=30; press mode, up x2, confirm -> set_all_times=01 for exactly 8 clk with btn_time_set=14, btn_min_set=30; then 00, editing=0.
- Wrap: press mode, mode; with shadow minute 59, press up -> 0; press down -> 59. In hour with 0, press down -> 23.
- Remind: press mode x3, then up from cur_remind_hour=23 -> 1; confirm -> set_all_times=10 for 8 clk, btn_time_set=1, btn_min_set=0.
- Bounce: toggle btn_up every 2 clk for 20 clk, then hold high -> exactly one increment.
- Simultaneous up+down pulses -> value unchanged.
- Abort and timeout:
  - Drop power_on mid-COMMIT_TIME -> set_all_times=00 on next clk.
  - No press for 64 clk in EDIT_MIN -> IDLE with set_all_times never 01.
